// File: rtl/cmac_pkg.sv
// rtl/cmac_pkg.sv - shared CMAC constants, FSM state type and block helpers
//
// Contents:
//   CMAC_BLK_W   cipher block width
//   CMAC_RB      reduction constant for subkey doubling in GF(2^128)
//   cmac_state_t controller state encoding
//   cmac_dbl     multiply-by-x in GF(2^128), used for K1/K2 derivation
//   cmac_pad     keep the top len bits of a block, append the 10* marker
package cmac_pkg;

    localparam int CMAC_BLK_W = 128;
    localparam logic [CMAC_BLK_W-1:0] CMAC_RB = 128'h87;

    typedef enum logic [2:0] {
        NOKEY,
        KGEN,
        DERIVE,
        READY,
        BLK,
        WAIT,
        TAG
    } cmac_state_t;

    function automatic logic [CMAC_BLK_W-1:0] cmac_dbl(input logic [CMAC_BLK_W-1:0] x);
        return {x[CMAC_BLK_W-2:0], 1'b0} ^ (x[CMAC_BLK_W-1] ? CMAC_RB : '0);
    endfunction

    // len is the number of valid MSB-aligned bits, strictly below a full block.
    function automatic logic [CMAC_BLK_W-1:0] cmac_pad(input logic [CMAC_BLK_W-1:0] data,
                                                        input logic [6:0]            len);
        logic [CMAC_BLK_W-1:0] keep;
        keep = ~({CMAC_BLK_W{1'b1}} >> len);
        return (data & keep) | ({1'b1, {(CMAC_BLK_W-1){1'b0}}} >> len);
    endfunction

endpackage

// File: rtl/cmac_pad_xor.sv
// rtl/cmac_pad_xor.sv - combinational message-block formatting for CMAC
//
// Ports:
//   text_in  raw block data (MSB-aligned)
//   last     block is the final one of its message
//   len      valid bits in a final block (>=128 means complete)
//   k1, k2   derived subkeys
//   m        formatted block, ready to be XORed into the chaining value
module cmac_pad_xor
    import cmac_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic [CMAC_BLK_W-1:0] text_in,
    input  logic                  last,
    input  logic [LEN_W-1:0]      len,
    input  logic [CMAC_BLK_W-1:0] k1,
    input  logic [CMAC_BLK_W-1:0] k2,
    output logic [CMAC_BLK_W-1:0] m
);

    logic [31:0] len32;
    logic        full;

    assign len32 = 32'(len);
    assign full  = (len32 >= 32'd128);

    always_comb begin
        m = text_in;
        if (last) begin
            if (full) begin
                m = text_in ^ k1;
            end else begin
                m = cmac_pad(text_in, len32[6:0]) ^ k2;
            end
        end
    end

endmodule

// File: rtl/cmac_mctx.sv
// rtl/cmac_mctx.sv - multi-context AES-CMAC controller driving an external AES-128 core
//
// Ports:
//   CLK, Rst                      clock, synchronous active-high reset
//   ld_Key, KEY, key_ready        key load handshake
//   key_valid                     subkeys derived, blocks accepted
//   blk_valid/blk_ready           block handshake with blk_ctx, blk_last, blk_len, TextIn
//   tag_valid/tag_ready           tag handshake with tag_ctx, TextOut
//   aes_start, aes_key, aes_in    request to the AES core
//   aes_done, aes_out             AES core completion
module cmac_mctx
    import cmac_pkg::*;
#(
    parameter int NUM_CTX = 4,
    parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
    parameter int TAG_W   = 128,
    parameter int LEN_W   = 8
) (
    input  logic                  CLK,
    input  logic                  Rst,
    input  logic                  ld_Key,
    input  logic [CMAC_BLK_W-1:0] KEY,
    output logic                  key_ready,
    output logic                  key_valid,
    input  logic                  blk_valid,
    output logic                  blk_ready,
    input  logic [CTX_W-1:0]      blk_ctx,
    input  logic                  blk_last,
    input  logic [LEN_W-1:0]      blk_len,
    input  logic [CMAC_BLK_W-1:0] TextIn,
    output logic                  tag_valid,
    input  logic                  tag_ready,
    output logic [CTX_W-1:0]      tag_ctx,
    output logic [TAG_W-1:0]      TextOut,
    output logic                  aes_start,
    output logic [CMAC_BLK_W-1:0] aes_key,
    output logic [CMAC_BLK_W-1:0] aes_in,
    input  logic                  aes_done,
    input  logic [CMAC_BLK_W-1:0] aes_out
);

    cmac_state_t state, state_nx;

    logic [CMAC_BLK_W-1:0] key_r;
    logic [CMAC_BLK_W-1:0] k1;
    logic [CMAC_BLK_W-1:0] k2;
    logic [CMAC_BLK_W-1:0] chain [NUM_CTX];
    logic [CMAC_BLK_W-1:0] aes_in_r;
    logic [CMAC_BLK_W-1:0] m;
    logic                  aes_start_r;
    logic [CTX_W-1:0]      cur_ctx;
    logic                  cur_last;
    logic [TAG_W-1:0]      tag_r;
    logic [CTX_W-1:0]      tag_ctx_r;

    logic ctx_ok;
    logic key_acc;
    logic blk_acc;

    // Out-of-range context ids are swallowed: handshake completes, nothing else happens.
    assign ctx_ok  = (32'(blk_ctx) < NUM_CTX);
    assign key_acc = ld_Key && key_ready;
    assign blk_acc = blk_valid && blk_ready && ctx_ok;

    cmac_pad_xor #(
        .LEN_W (LEN_W)
    ) u_pad (
        .text_in (TextIn),
        .last    (blk_last),
        .len     (blk_len),
        .k1      (k1),
        .k2      (k2),
        .m       (m)
    );

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state <= NOKEY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        key_ready = 1'b0;
        key_valid = 1'b0;
        blk_ready = 1'b0;
        tag_valid = 1'b0;
        case (state)
            NOKEY: begin
                key_ready = 1'b1;
                if (ld_Key) state_nx = KGEN;
            end
            KGEN: begin
                if (aes_done) state_nx = DERIVE;
            end
            DERIVE: begin
                state_nx = READY;
            end
            READY: begin
                key_ready = 1'b1;
                key_valid = 1'b1;
                // A key load wins over a block offered in the same cycle.
                blk_ready = !ld_Key;
                if (ld_Key) begin
                    state_nx = KGEN;
                end else if (blk_valid && ctx_ok) begin
                    state_nx = BLK;
                end
            end
            BLK: begin
                key_valid = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                key_valid = 1'b1;
                if (aes_done) state_nx = cur_last ? TAG : READY;
            end
            TAG: begin
                key_valid = 1'b1;
                tag_valid = 1'b1;
                if (tag_ready) state_nx = READY;
            end
            default: begin
                state_nx = NOKEY;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            key_r       <= '0;
            k1          <= '0;
            k2          <= '0;
            aes_in_r    <= '0;
            aes_start_r <= 1'b0;
            cur_ctx     <= '0;
            cur_last    <= 1'b0;
            tag_r       <= '0;
            tag_ctx_r   <= '0;
            for (int i = 0; i < NUM_CTX; i++) chain[i] <= '0;
        end else begin
            aes_start_r <= 1'b0;
            if (key_acc) begin
                key_r       <= KEY;
                aes_in_r    <= '0;
                aes_start_r <= 1'b1;
                for (int i = 0; i < NUM_CTX; i++) chain[i] <= '0;
            end else if (blk_acc) begin
                aes_in_r    <= chain[blk_ctx] ^ m;
                aes_start_r <= 1'b1;
                cur_ctx     <= blk_ctx;
                cur_last    <= blk_last;
            end

            // k1 temporarily holds L = E(K, 0) until DERIVE turns it into K1/K2.
            if (state == KGEN && aes_done) begin
                k1 <= aes_out;
            end
            if (state == DERIVE) begin
                k1 <= cmac_dbl(k1);
                k2 <= cmac_dbl(cmac_dbl(k1));
            end

            if (state == WAIT && aes_done) begin
                if (cur_last) begin
                    chain[cur_ctx] <= '0;
                    tag_r          <= aes_out[CMAC_BLK_W-1 -: TAG_W];
                    tag_ctx_r      <= cur_ctx;
                end else begin
                    chain[cur_ctx] <= aes_out;
                end
            end
        end
    end

    assign aes_start = aes_start_r;
    assign aes_in    = aes_in_r;
    assign aes_key   = key_r;
    assign TextOut   = tag_r;
    assign tag_ctx   = tag_ctx_r;

endmodule

// File: doc/cmac_mctx.md
Name: cmac_mctx

Overview:
- Parametrised multi-context AES-CMAC controller (NIST SP 800-38B), successor to the single-stream CMAC top.
- Derives subkeys K1/K2 and pads/finalises the last block.
- Keeps up to NUM_CTX interleaved messages in flight, each with its own chaining value; returns a truncatable tag through a valid/ready handshake.
- Drives an external AES-128 encrypt core over a start/done interface of arbitrary latency; sits between the DMA/packet front end and the AES core.

Parameters:
- NUM_CTX, 4, number of independent message contexts (1..16)
- CTX_W, $clog2(NUM_CTX) min 1, context-id width
- TAG_W, 128, emitted tag width; tag = TAG_W MSBs of the full MAC (8..128, multiple of 8)
- LEN_W, 8, width of last-block bit-length field

Ports:
- CLK  in  1  clock
- Rst  in  1  synchronous active-high reset
- ld_Key  in  1  key load request, accepted when key_ready=1
- KEY  in  128  cipher key, sampled on accepted ld_Key
- key_ready  out  1  key load may be accepted
- key_valid  out  1  subkeys derived; blocks may be accepted
- blk_valid  in  1  block offered
- blk_ready  out  1  block accepted this cycle if blk_valid=1
- blk_ctx  in  CTX_W  context id of offered block
- blk_last  in  1  final block of message
- blk_len  in  LEN_W  valid bits in final block (MSB-aligned), 0..128
- TextIn  in  128  block data
- tag_valid  out  1  tag available
- tag_ready  in  1  tag consumer ready
- tag_ctx  out  CTX_W  context the tag belongs to
- TextOut  out  TAG_W  CMAC tag
- aes_start  out  1  one-cycle request to AES core
- aes_key  out  128  stored key to AES core
- aes_in  out  128  AES plaintext
- aes_done  in  1  one-cycle AES completion strobe
- aes_out  in  128  AES ciphertext, valid with aes_done

Behaviour:
- Reset: FSM=NOKEY; all outputs 0 except key_ready=1. All chaining registers, K1, K2, key cleared.
- States: NOKEY, KGEN, DERIVE, READY, BLK, WAIT, TAG.
- Key load:
  - ld_Key accepted in NOKEY or READY with no tag pending.
  - Latch KEY, clear all NUM_CTX chains, key_valid=0, key_ready=0.
  - Next cycle: aes_start=1, aes_in=0; enter KGEN.
  - On aes_done: L=aes_out.
  - DERIVE (1 cycle): K1=(L<<1)^(L[127]?0x87:0); K2=(K1<<1)^(K1[127]?0x87:0).
  - Then READY with key_valid=1, key_ready=1.
- Block acceptance:
  - blk_ready=1 only in READY; ld_Key has priority if both are asserted.
  - On accept, M is computed from TextIn:
    - Not last: M=TextIn; blk_len ignored.
    - Last, blk_len>=128: M=TextIn^K1.
    - Last, blk_len<128: keep the top blk_len bits of TextIn; set bit (127-blk_len) to 1; zero the rest; XOR with K2.
    - blk_len=0 with last: empty-message block 0x80..00^K2.
  - aes_in = chain[blk_ctx] ^ M. aes_start is registered: asserts the cycle after accept (state BLK), then WAIT.
- On aes_done in WAIT:
  - Not last: chain[ctx]=aes_out; return to READY.
  - Last: chain[ctx]=0; TextOut=aes_out[127 -: TAG_W]; tag_ctx=ctx; tag_valid=1; enter TAG.
- TAG: hold tag_valid/TextOut/tag_ctx stable until tag_ready=1; then tag_valid=0 in the following cycle and return to READY.
- Latency: accept->aes_start 1 cycle; aes_done->tag_valid 1 cycle; aes_done->blk_ready for a non-last block 1 cycle.
- Interleaving: contexts share the AES core serially. Any order of blk_ctx is legal; each chain is independent.
- blk_ctx>=NUM_CTX: block accepted and discarded. No AES start; state stays READY; blk_ready stays 1.
- aes_done outside KGEN/WAIT: ignored.
- Rst mid-operation: immediate return to reset state. Any pending AES result is ignored, because the state is not KGEN/WAIT.

Decomposition:
- Shared package cmac_pkg:
  - CMAC_BLK_W=128
  - CMAC_RB=128'h87
  - state enum type
  - functions cmac_dbl(x) (subkey doubling) and cmac_pad(data,len)
- One natural sub-module cmac_pad_xor: combinational M generation from TextIn/last/len/K1/K2.
- Chain storage is an internal NUM_CTX x 128 register array.

Test Plan:
All cases use KEY=2b7e151628aed2a6abf7158809cf4f3c, a behavioural AES model and full-width tags unless stated.
- Reset then ld_Key -> L=7df76b0c1ab899b33e42f047b91b546f; K1=fbeed618357133667c85e08f7236a8de; K2=f7ddac306ae266ccf90bc11ee46d513b; key_valid=1.
- Empty message (blk_last=1, blk_len=0, TextIn=0) -> tag bb1d6929e95937287fa37d129b756746 on tag_ctx=0.
- One block 6bc1bee22e409f96e93d7e117393172a, last, len=128 -> tag 070a16b46b4d4144f79bdd9dd04a287c.
- 40-byte message, interleaved:
  - ctx1 blocks 6bc1bee2..172a, ae2d8a57..8e51, then 30c81c46a35ce411 (len=64, last).
  - ctx2 single-block message interleaved between them.
  - Expected: ctx1 tag dfa66747de9ae63030ca32611497c827; ctx2 tag unaffected.
- Backpressure: tag_ready=0 for 20 cycles -> tag_valid/TextOut stable, blk_ready=0 throughout. TAG_W=64 build -> TextOut=070a16b46b4d4144.
- Rst asserted while in WAIT -> all outputs return to reset values; a late aes_done is ignored. Re-key, then repeat the one-block test -> same tag.
